// File: rtl/regfile_read_port_arbiter.sv
// Arbitrates the register-file Rd1 read port between core decode and a debug/trace requester.
// Core always wins; a debug read starved for STARVE_LIMIT busy cycles forces one decode stall.
module regfile_read_port_arbiter #(
    parameter int BIT_COUNT    = 64,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd_en,
    input  logic [ADDR_WIDTH-1:0] core_rs1,
    output logic [BIT_COUNT-1:0]  core_rd1,
    output logic                  stall_req,
    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic                  dbg_rsp_valid,
    input  logic                  dbg_rsp_ready,
    output logic [BIT_COUNT-1:0]  dbg_rsp_data,
    output logic [ADDR_WIDTH-1:0] rf_a1,
    input  logic [BIT_COUNT-1:0]  rf_rd1
);

    localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        STALL,
        RESP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      starve_cnt;
    logic [BIT_COUNT-1:0]  rsp_data_q;
    logic                  req_fire;

    assign req_fire = dbg_req_valid & dbg_req_ready;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            starve_cnt <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        addr_q     <= dbg_addr;
                        starve_cnt <= '0;
                        state      <= PEND;
                    end
                end
                PEND: begin
                    if (!core_rd_en) begin
                        rsp_data_q <= rf_rd1;
                        state      <= RESP;
                    end else if (starve_cnt == STARVE_LAST) begin
                        state <= STALL;
                    end else begin
                        starve_cnt <= starve_cnt + CNT_W'(1);
                    end
                end
                STALL: begin
                    rsp_data_q <= rf_rd1;
                    state      <= RESP;
                end
                RESP: begin
                    if (dbg_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Debug only borrows the port when decode is idle, or during the single forced stall.
    // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latch).
    always_comb begin
        rf_a1    = core_rs1;
        core_rd1 = rf_rd1;
        if (state == STALL) begin
            rf_a1    = addr_q;
            core_rd1 = '0;
        end else if (state == PEND && !core_rd_en) begin
            rf_a1 = addr_q;
        end
    end

    assign stall_req     = (state == STALL);
    assign dbg_req_ready = reset & (state == IDLE);
    assign dbg_rsp_valid = (state == RESP);
    assign dbg_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_port_arbiter.sv
// Directed bench for regfile_read_port_arbiter with a behavioural 32-entry register file.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_regfile_read_port_arbiter;

    localparam int BW = 64;
    localparam int AW = 5;
    localparam int SL = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_rd_en;
    logic [AW-1:0] core_rs1;
    logic [BW-1:0] core_rd1;
    logic          stall_req;
    logic          dbg_req_valid;
    logic          dbg_req_ready;
    logic [AW-1:0] dbg_addr;
    logic          dbg_rsp_valid;
    logic          dbg_rsp_ready;
    logic [BW-1:0] dbg_rsp_data;
    logic [AW-1:0] rf_a1;
    logic [BW-1:0] rf_rd1;

    logic [BW-1:0] regs [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // x0 is hardwired to zero regardless of what was written into the array.
    assign rf_rd1 = (rf_a1 == '0) ? '0 : regs[rf_a1];

    regfile_read_port_arbiter #(
        .BIT_COUNT   (BW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_rd_en   (core_rd_en),
        .core_rs1     (core_rs1),
        .core_rd1     (core_rd1),
        .stall_req    (stall_req),
        .dbg_req_valid(dbg_req_valid),
        .dbg_req_ready(dbg_req_ready),
        .dbg_addr     (dbg_addr),
        .dbg_rsp_valid(dbg_rsp_valid),
        .dbg_rsp_ready(dbg_rsp_ready),
        .dbg_rsp_data (dbg_rsp_data),
        .rf_a1        (rf_a1),
        .rf_rd1       (rf_rd1)
    );

    // Presents a one-cycle debug request; acc reports whether ready was high for it.
    task automatic send_req(input logic [AW-1:0] a, input logic busy, input logic [AW-1:0] rs1,
                            output logic acc);
        @(negedge clk);
        dbg_req_valid = 1'b1;
        dbg_addr      = a;
        core_rd_en    = busy;
        core_rs1      = rs1;
        #1 acc = dbg_req_ready;
    endtask

    task automatic test_reset;
        reset         = 1'b0;
        core_rd_en    = 1'b1;
        core_rs1      = 5'd3;
        dbg_req_valid = 1'b1;
        dbg_addr      = 5'd4;
        dbg_rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total += 5;
        if (dbg_req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", dbg_req_ready); end
        if (dbg_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", dbg_rsp_valid); end
        if (dbg_rsp_data !== 64'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", dbg_rsp_data); end
        if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_req); end
        if (core_rd1 !== 64'hCAFE_0003) begin bad++; $display("FAIL reset_core_rd1 got=%h want=cafe0003", core_rd1); end
        @(negedge clk);
        reset         = 1'b1;
        dbg_req_valid = 1'b0;
        core_rd_en    = 1'b0;
        #1;
        total++;
        if (dbg_req_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", dbg_req_ready); end
    endtask

    task automatic test_idle_read;
        logic acc;
        regs[5] = 64'h1234;
        send_req(5'd5, 1'b0, 5'd1, acc);
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL idle_accept got=%b want=1", acc); end
        @(negedge clk);
        dbg_req_valid = 1'b0;
        #1;
        total += 4;
        if (dbg_rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_c1_valid got=%b want=0", dbg_rsp_valid); end
        if (stall_req !== 1'b0) begin bad++; $display("FAIL idle_c1_stall got=%b want=0", stall_req); end
        if (rf_a1 !== 5'd5) begin bad++; $display("FAIL idle_c1_a1 got=%0d want=5", rf_a1); end
        if (dbg_req_ready !== 1'b0) begin bad++; $display("FAIL idle_c1_ready got=%b want=0", dbg_req_ready); end
        @(negedge clk);
        dbg_rsp_ready = 1'b1;
        #1;
        total += 3;
        if (dbg_rsp_valid !== 1'b1) begin bad++; $display("FAIL idle_c2_valid got=%b want=1", dbg_rsp_valid); end
        if (dbg_rsp_data !== 64'h1234) begin bad++; $display("FAIL idle_c2_data got=%h want=1234", dbg_rsp_data); end
        if (stall_req !== 1'b0) begin bad++; $display("FAIL idle_c2_stall got=%b want=0", stall_req); end
        @(negedge clk);
        dbg_rsp_ready = 1'b0;
        #1;
        total += 2;
        if (dbg_rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_c3_valid got=%b want=0", dbg_rsp_valid); end
        if (dbg_req_ready !== 1'b1) begin bad++; $display("FAIL idle_c3_ready got=%b want=1", dbg_req_ready); end
    endtask

    // Decode busy every cycle: stall lands on the 9th cycle after accept, response on the 10th.
    task automatic test_starve;
        logic acc;
        logic exp_stall, exp_valid;
        logic [AW-1:0] exp_a1;
        logic [BW-1:0] exp_rd1;
        send_req(5'd9, 1'b1, 5'd7, acc);
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL starve_accept got=%b want=1", acc); end
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            dbg_req_valid = 1'b0;
            core_rd_en    = 1'b1;
            core_rs1      = 5'd7;
            #1;
            exp_stall = (k == 9);
            exp_valid = (k >= 10);
            exp_a1    = (k == 9) ? 5'd9 : 5'd7;
            exp_rd1   = (k == 9) ? 64'h0 : 64'hCAFE_0007;
            total += 4;
            if (stall_req !== exp_stall) begin bad++; $display("FAIL starve_stall k=%0d got=%b want=%b", k, stall_req, exp_stall); end
            if (dbg_rsp_valid !== exp_valid) begin bad++; $display("FAIL starve_valid k=%0d got=%b want=%b", k, dbg_rsp_valid, exp_valid); end
            if (rf_a1 !== exp_a1) begin bad++; $display("FAIL starve_a1 k=%0d got=%0d want=%0d", k, rf_a1, exp_a1); end
            if (core_rd1 !== exp_rd1) begin bad++; $display("FAIL starve_rd1 k=%0d got=%h want=%h", k, core_rd1, exp_rd1); end
        end
        total++;
        if (dbg_rsp_data !== 64'hCAFE_0009) begin bad++; $display("FAIL starve_data got=%h want=cafe0009", dbg_rsp_data); end
        @(negedge clk);
        dbg_rsp_ready = 1'b1;
        core_rd_en    = 1'b0;
        @(negedge clk);
        dbg_rsp_ready = 1'b0;
        #1;
        total++;
        if (dbg_req_ready !== 1'b1) begin bad++; $display("FAIL starve_ready_back got=%b want=1", dbg_req_ready); end
    endtask

    // Response held under back-pressure while a second request knocks; it must not be taken.
    task automatic test_backpressure;
        logic acc;
        regs[12] = 64'hDEAD_BEEF_0000_0012;
        send_req(5'd12, 1'b0, 5'd1, acc);
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL bp_accept got=%b want=1", acc); end
        @(negedge clk);
        dbg_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dbg_req_valid = 1'b1;
            dbg_addr      = 5'd3;
            #1;
            total += 3;
            if (dbg_rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid i=%0d got=%b want=1", i, dbg_rsp_valid); end
            if (dbg_rsp_data !== 64'hDEAD_BEEF_0000_0012) begin bad++; $display("FAIL bp_data i=%0d got=%h want=deadbeef00000012", i, dbg_rsp_data); end
            if (dbg_req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready i=%0d got=%b want=0", i, dbg_req_ready); end
        end
        @(negedge clk);
        dbg_req_valid = 1'b0;
        dbg_rsp_ready = 1'b1;
        #1;
        total++;
        if (dbg_rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_hs_valid got=%b want=1", dbg_rsp_valid); end
        @(negedge clk);
        dbg_rsp_ready = 1'b0;
        #1;
        total += 2;
        if (dbg_req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", dbg_req_ready); end
        if (dbg_rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%b want=0", dbg_rsp_valid); end
    endtask

    task automatic test_reset_mid;
        logic acc;
        send_req(5'd4, 1'b1, 5'd7, acc);
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL rmid_accept got=%b want=1", acc); end
        repeat (2) begin
            @(negedge clk);
            dbg_req_valid = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total += 5;
        if (stall_req !== 1'b0) begin bad++; $display("FAIL rmid_stall got=%b want=0", stall_req); end
        if (dbg_rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", dbg_rsp_valid); end
        if (dbg_req_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%b want=0", dbg_req_ready); end
        if (dbg_rsp_data !== 64'h0) begin bad++; $display("FAIL rmid_data got=%h want=0", dbg_rsp_data); end
        if (core_rd1 !== 64'hCAFE_0007) begin bad++; $display("FAIL rmid_rd1 got=%h want=cafe0007", core_rd1); end
        @(negedge clk);
        reset      = 1'b1;
        core_rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            total += 2;
            if (dbg_rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale_valid i=%0d got=%b want=0", i, dbg_rsp_valid); end
            if (dbg_req_ready !== 1'b1) begin bad++; $display("FAIL rmid_idle_ready i=%0d got=%b want=1", i, dbg_req_ready); end
        end
    endtask

    task automatic test_x0;
        logic acc;
        regs[0] = 64'hFFFF;
        send_req(5'd0, 1'b0, 5'd1, acc);
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL x0_accept got=%b want=1", acc); end
        @(negedge clk);
        dbg_req_valid = 1'b0;
        @(negedge clk);
        dbg_rsp_ready = 1'b1;
        #1;
        total += 2;
        if (dbg_rsp_valid !== 1'b1) begin bad++; $display("FAIL x0_valid got=%b want=1", dbg_rsp_valid); end
        if (dbg_rsp_data !== 64'h0) begin bad++; $display("FAIL x0_data got=%h want=0", dbg_rsp_data); end
        @(negedge clk);
        dbg_rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic          en;
        logic [AW-1:0] rs1;
        logic [AW-1:0] a1;
        logic [BW-1:0] rd1;
        logic          valid;
    } vec_t;

    // Decode stream with a debug read of x2 slipping into the one idle slot (cycle 4).
    task automatic test_lockstep;
        logic acc;
        vec_t tbl [8];
        tbl[0] = '{1'b1, 5'd1,  5'd1,  64'hCAFE_0001, 1'b0};
        tbl[1] = '{1'b1, 5'd3,  5'd3,  64'hCAFE_0003, 1'b0};
        tbl[2] = '{1'b1, 5'd6,  5'd6,  64'hCAFE_0006, 1'b0};
        tbl[3] = '{1'b0, 5'd8,  5'd2,  64'hCAFE_0002, 1'b0};
        tbl[4] = '{1'b1, 5'd10, 5'd10, 64'hCAFE_000A, 1'b1};
        tbl[5] = '{1'b1, 5'd0,  5'd0,  64'h0,         1'b1};
        tbl[6] = '{1'b1, 5'd11, 5'd11, 64'hCAFE_000B, 1'b1};
        tbl[7] = '{1'b0, 5'd5,  5'd5,  64'h1234,      1'b1};
        send_req(5'd2, 1'b1, 5'd9, acc);
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL ls_accept got=%b want=1", acc); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            dbg_req_valid = 1'b0;
            core_rd_en    = tbl[k].en;
            core_rs1      = tbl[k].rs1;
            #1;
            total += 4;
            if (rf_a1 !== tbl[k].a1) begin bad++; $display("FAIL ls_a1 k=%0d got=%0d want=%0d", k, rf_a1, tbl[k].a1); end
            if (core_rd1 !== tbl[k].rd1) begin bad++; $display("FAIL ls_rd1 k=%0d got=%h want=%h", k, core_rd1, tbl[k].rd1); end
            if (stall_req !== 1'b0) begin bad++; $display("FAIL ls_stall k=%0d got=%b want=0", k, stall_req); end
            if (dbg_rsp_valid !== tbl[k].valid) begin bad++; $display("FAIL ls_valid k=%0d got=%b want=%b", k, dbg_rsp_valid, tbl[k].valid); end
        end
        total++;
        if (dbg_rsp_data !== 64'hCAFE_0002) begin bad++; $display("FAIL ls_data got=%h want=cafe0002", dbg_rsp_data); end
        @(negedge clk);
        dbg_rsp_ready = 1'b1;
        core_rd_en    = 1'b0;
        @(negedge clk);
        dbg_rsp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 64'hCAFE_0000 + 64'(i);
        test_reset;
        test_idle_read;
        test_starve;
        test_backpressure;
        test_reset_mid;
        test_x0;
        test_lockstep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
